// File: rtl/store_serializer.sv
// Purpose : serialise a 1/2/4/8-byte store into single-byte writes to an 8-bit data memory.
// Latency : accept at edge N, bytes in cycles N+1..N+n, done in N+n+1, ready again in N+n+2.
// Backpressure: req_ready only in IDLE; mem_stall freezes the current byte and adds one cycle each.
module store_serializer #(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_stall,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Registered request; only loaded on an accepting edge so inputs are
    // free to change while a store is in flight.
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_data;
    logic [1:0]        r_size;
    logic [2:0]        r_idx;
    logic              r_err;

    logic              w_accept;
    logic              w_misaligned;
    logic              w_last_byte;
    logic              w_byte_done;
    logic [2:0]        w_last_idx;

    // A store of 2^size bytes must sit on a 2^size-byte boundary.
    function automatic logic is_misaligned(input logic [2:0] a_lo, input logic [1:0] sz);
        logic r;
        case (sz)
            2'b00:   r = 1'b0;
            2'b01:   r = a_lo[0];
            2'b10:   r = |a_lo[1:0];
            default: r = |a_lo;
        endcase
        return r;
    endfunction

    // Index of the final byte for a given size (n-1).
    function automatic logic [2:0] last_index(input logic [1:0] sz);
        logic [2:0] r;
        case (sz)
            2'b00:   r = 3'd0;
            2'b01:   r = 3'd1;
            2'b10:   r = 3'd3;
            default: r = 3'd7;
        endcase
        return r;
    endfunction

    // Handshake, alignment and byte-progress decode.
    always_comb begin
        w_accept     = req_valid && (r_state == S_IDLE);
        w_misaligned = is_misaligned(req_addr[2:0], req_size);
        w_last_idx   = last_index(r_size);
        w_last_byte  = (r_idx == w_last_idx);
        w_byte_done  = (r_state == S_WRITE) && !mem_stall;
    end

    // Control FSM and request capture; reset wins over any pending request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_size  <= 2'b00;
            r_idx   <= 3'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_data  <= req_data;
                        r_size  <= req_size;
                        r_idx   <= 3'd0;
                        r_err   <= w_misaligned;
                        r_state <= w_misaligned ? S_DONE : S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (w_byte_done) begin
                        if (w_last_byte) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode from state only; address wraps naturally at ADDR_W bits,
    // and only bytes 0..n-1 are ever selected so upper data bytes never appear.
    always_comb begin
        req_ready = (r_state == S_IDLE);
        mem_we    = (r_state == S_WRITE);
        done      = (r_state == S_DONE);
        err       = (r_state == S_DONE) && r_err;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        if (r_state == S_WRITE) begin
            mem_addr  = r_addr + ADDR_W'(r_idx);
            mem_wdata = r_data[{r_idx, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_store_serializer.sv
// Purpose : self-checking bench for store_serializer (directed table, corner sequences, random vs model).
// Latency : measured from acceptance edge to the done cycle and compared against the model.
// Backpressure: mem_stall is driven per write cycle from a mask; stalled bytes must hold.
module tb_store_serializer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_size;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_stall;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [71:0] obs_q[$];
    logic [71:0] exp_q[$];

    store_serializer #(.ADDR_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_stall (mem_stall),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    // Reference: an aligned store emits bytes 0..n-1 at addr+i (mod 2^64);
    // every mem_we cycle whose mask bit is set is a stall that re-offers the same byte.
    task automatic model(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                         input logic [15:0] m, output logic e, output int lat, output int wec);
        int n;
        int k;
        int w;
        n = 1 << sz;
        exp_q.delete();
        e = ((a % 64'(n)) != 64'd0);
        if (e) begin
            lat = 1;
            wec = 0;
        end else begin
            k = 0;
            w = 0;
            while (w < n) begin
                if (!(k < 16 && m[k])) begin
                    exp_q.push_back({a + 64'(w), d[8*w +: 8]});
                    w++;
                end
                k++;
            end
            wec = k;
            lat = k + 1;
        end
    endtask

    // Drive one request from an IDLE negedge; returns at the IDLE negedge after done.
    task automatic run_req(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                           input logic [15:0] m, output logic e, output int lat, output int wec);
        logic        stalled_prev;
        logic [72:0] prev;
        obs_q.delete();
        e = 1'b0;
        lat = 0;
        wec = 0;
        prev = '0;
        check("ready_before_req", 128'(req_ready), 128'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        @(negedge clk);
        // Scramble inputs while busy; the registered request must not notice.
        req_valid = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_data  = {$urandom, $urandom};
        req_size  = 2'($urandom);
        lat = 1;
        stalled_prev = 1'b0;
        while (!done && lat < 64) begin
            if (stalled_prev)
                check("stall_hold", 128'({mem_we, mem_addr, mem_wdata}), 128'(prev));
            if (mem_we) begin
                mem_stall = (wec < 16) ? m[wec] : 1'b0;
                if (!mem_stall) obs_q.push_back({mem_addr, mem_wdata});
                prev = {1'b1, mem_addr, mem_wdata};
                stalled_prev = mem_stall;
                wec++;
            end else begin
                mem_stall = 1'($urandom);
                stalled_prev = 1'b0;
            end
            @(negedge clk);
            lat++;
            req_valid = 1'($urandom);
            req_addr  = {$urandom, $urandom};
            req_data  = {$urandom, $urandom};
            req_size  = 2'($urandom);
        end
        if (!done) check("done_timeout", 128'(done), 128'd1);
        e = err;
        check("we_low_in_done", 128'(mem_we), 128'd0);
        req_valid = 1'b0;
        mem_stall = 1'b0;
        @(negedge clk);
        check("ready_after_done", 128'(req_ready), 128'd1);
        check("done_single_pulse", 128'(done), 128'd0);
    endtask

    task automatic apply(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                         input logic [15:0] m, output logic e, output int lat, output int wec);
        logic me;
        int   ml;
        int   mw;
        run_req(a, d, sz, m, e, lat, wec);
        model(a, d, sz, m, me, ml, mw);
        check("err", 128'(e), 128'(me));
        check("latency", 128'(lat), 128'(ml));
        check("we_cycles", 128'(wec), 128'(mw));
        check("nwrites", 128'(obs_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check("write", 128'(obs_q[i]), 128'(exp_q[i]));
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
        logic [15:0] smask;
        logic        exp_err;
        int          exp_lat;
        int          exp_nw;
        logic [63:0] exp_last_addr;
        logic [7:0]  exp_last_byte;
    } vec_t;

    vec_t vecs[7];

    logic        we_a[1:5];
    logic [63:0] ad_a[1:5];
    logic [7:0]  wd_a[1:5];
    logic        dn_a[1:5];
    logic        er_a[1:5];
    logic        rd_a[1:5];

    initial begin
        logic        e;
        int          lat;
        int          wec;
        logic [63:0] ra;
        logic [63:0] rdat;
        logic [1:0]  rs;
        logic [15:0] rm;

        vecs[0] = '{64'h100, 64'h8877665544332211, 2'b11, 16'h0000, 1'b0, 9, 8, 64'h107, 8'h88};
        vecs[1] = '{64'h203, 64'hFFFF_FFFF_FFFF_FFAB, 2'b00, 16'h0000, 1'b0, 2, 1, 64'h203, 8'hAB};
        vecs[2] = '{64'h102, 64'h0123456789ABCDEF, 2'b10, 16'h0000, 1'b1, 1, 0, 64'h0, 8'h00};
        vecs[3] = '{64'h10, 64'h0000_0000_0000_BEEF, 2'b01, 16'h0003, 1'b0, 5, 2, 64'h11, 8'hBE};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h1234, 2'b01, 16'h0000, 1'b0, 3, 2, 64'hFFFF_FFFF_FFFF_FFFF, 8'h12};
        vecs[5] = '{64'h7, 64'h55, 2'b01, 16'h0000, 1'b1, 1, 0, 64'h0, 8'h00};
        vecs[6] = '{64'h8, 64'hCAFEF00D11223344, 2'b10, 16'h0004, 1'b0, 6, 4, 64'hB, 8'h11};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = 2'b00;
        mem_stall = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 128'(req_ready), 128'd1);
        check("rst_we", 128'(mem_we), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_err", 128'(err), 128'd0);
        check("rst_addr", 128'(mem_addr), 128'd0);
        check("rst_wdata", 128'(mem_wdata), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int v = 0; v < 7; v++) begin
            apply(vecs[v].addr, vecs[v].data, vecs[v].size, vecs[v].smask, e, lat, wec);
            check("tbl_err", 128'(e), 128'(vecs[v].exp_err));
            check("tbl_lat", 128'(lat), 128'(vecs[v].exp_lat));
            check("tbl_nw", 128'(obs_q.size()), 128'(vecs[v].exp_nw));
            if (vecs[v].exp_nw > 0 && obs_q.size() > 0)
                check("tbl_last", 128'(obs_q[obs_q.size()-1]),
                      128'({vecs[v].exp_last_addr, vecs[v].exp_last_byte}));
        end

        // Wrap store with req_valid held high: re-accepted one cycle after done.
        req_valid = 1'b1;
        req_addr  = 64'hFFFF_FFFF_FFFF_FFFE;
        req_data  = 64'h1234;
        req_size  = 2'b01;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            we_a[c] = mem_we;
            ad_a[c] = mem_addr;
            wd_a[c] = mem_wdata;
            dn_a[c] = done;
            er_a[c] = err;
            rd_a[c] = req_ready;
        end
        req_valid = 1'b0;
        check("b2b_c1", 128'({we_a[1], ad_a[1], wd_a[1]}), 128'({1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'h34}));
        check("b2b_c2", 128'({we_a[2], ad_a[2], wd_a[2]}), 128'({1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h12}));
        check("b2b_c3_done", 128'({dn_a[3], er_a[3], we_a[3], rd_a[3]}), 128'(4'b1000));
        check("b2b_c4_idle", 128'({dn_a[4], we_a[4], rd_a[4]}), 128'(3'b001));
        check("b2b_c5_reaccept", 128'({we_a[5], ad_a[5], wd_a[5]}), 128'({1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'h34}));
        repeat (3) @(negedge clk);
        check("b2b_drained_ready", 128'(req_ready), 128'd1);

        // Reset in the middle of a dword store, after three bytes.
        req_valid = 1'b1;
        req_addr  = 64'h300;
        req_data  = 64'h0807060504030201;
        req_size  = 2'b11;
        @(negedge clk);
        req_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            check("rst_mid_byte", 128'({mem_we, mem_addr, mem_wdata}),
                  128'({1'b1, 64'h300 + 64'(b), 8'(b + 1)}));
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_we", 128'(mem_we), 128'd0);
        check("rst_mid_ready", 128'(req_ready), 128'd1);
        check("rst_mid_done", 128'(done), 128'd0);
        check("rst_mid_outs", 128'({err, mem_addr, mem_wdata}), 128'd0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("rst_no_done", 128'({done, mem_we}), 128'd0);
            @(negedge clk);
        end
        apply(64'h400, 64'hA1B2C3D4E5F60718, 2'b10, 16'h0000, e, lat, wec);

        // Reset and req_valid together: the request must not be taken.
        reset     = 1'b1;
        req_valid = 1'b1;
        req_addr  = 64'h40;
        req_size  = 2'b00;
        @(negedge clk);
        check("rst_vs_valid_we", 128'(mem_we), 128'd0);
        check("rst_vs_valid_ready", 128'(req_ready), 128'd1);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_vs_valid_idle", 128'({mem_we, done}), 128'd0);

        // Randomised requests against the model.
        for (int t = 0; t < 150; t++) begin
            ra   = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) ra[2:0] = 3'b000;
            rdat = {$urandom, $urandom};
            rs   = 2'($urandom);
            rm   = 16'($urandom & $urandom & $urandom);
            apply(ra, rdat, rs, rm, e, lat, wec);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
